wb_arbiter: RTL and testbench

Register-file write-port arbiter and writeback scheduler. Sits between the pipeline writeback register stage, the multi-cycle execution unit (multiplier/divider) and the single register-file write port. It merges the two result streams onto one registered write port with a fixed-priority valid/ready handshake and tracks outstanding multi-cycle destinations in a 16-entry scoreboard. It drops superseded multi-cycle results (WAW) and requests a pipeline bubble when the multi-cycle unit is starved.

---
 rtl/wb_arbiter_if.sv | 33 +++
 rtl/wb_arbiter.sv | 93 +++++++++
 tb/tb_wb_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline/multi-cycle result sources, scoreboard and
// register-file write port. master = upstream/driver side, slave = arbiter.
interface wb_arbiter_if;
  logic        pipe_write_in;
  logic [3:0]  pipe_rd_in;
  logic [31:0] pipe_data_in;
  logic        mc_issue;
  logic [3:0]  mc_issue_rd;
  logic        issue_ok;
  logic        mc_valid;
  logic [3:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy_mask;
  logic        stall_req;

  modport master (
    output pipe_write_in, pipe_rd_in, pipe_data_in,
    output mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    input  issue_ok, mc_ready,
    input  rf_we, rf_waddr, rf_wdata, busy_mask, stall_req
  );

  modport slave (
    input  pipe_write_in, pipe_rd_in, pipe_data_in,
    input  mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_data,
    output issue_ok, mc_ready,
    output rf_we, rf_waddr, rf_wdata, busy_mask, stall_req
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges pipeline and multi-cycle results onto one registered RF write port (1-cycle latency).
// Pipeline always wins; mc side is back-pressured via mc_ready and raises stall_req when starved.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [15:0] busy_q;
  logic [15:0] stale_q;
  logic [15:0] busy_d;
  logic [15:0] stale_d;
  logic [3:0]  starve_cnt;
  logic        stall_q;
  logic        rf_we_q;
  logic [3:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        mc_hs;
  logic        mc_blocked;

  assign bus.mc_ready  = ~bus.pipe_write_in;
  assign bus.issue_ok  = ~busy_q[bus.mc_issue_rd];
  assign mc_hs         = bus.mc_valid & ~bus.pipe_write_in;
  assign mc_blocked    = bus.mc_valid & bus.pipe_write_in;

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy_mask = busy_q;
  assign bus.stall_req = stall_q;

  // Order matters: commit clears first, then a younger issue to the same rd re-sets busy.
  always_comb begin
    busy_d  = busy_q;
    stale_d = stale_q;
    if (mc_hs) begin
      busy_d[bus.mc_rd]  = 1'b0;
      stale_d[bus.mc_rd] = 1'b0;
    end
    if (bus.pipe_write_in && busy_q[bus.pipe_rd_in]) begin
      stale_d[bus.pipe_rd_in] = 1'b1;
    end
    if (bus.mc_issue) begin
      busy_d[bus.mc_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 4'd0;
      rf_wdata_q <= 32'd0;
      busy_q     <= 16'd0;
      stale_q    <= 16'd0;
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      stale_q <= stale_d;

      if (bus.pipe_write_in) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.pipe_rd_in;
        rf_wdata_q <= bus.pipe_data_in;
      end else if (mc_hs && !stale_q[bus.mc_rd]) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.mc_rd;
        rf_wdata_q <= bus.mc_data;
      end else begin
        // Superseded mc results and idle cycles leave address/data untouched.
        rf_we_q <= 1'b0;
      end

      if (mc_blocked) begin
        starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end

      // Stall holds until the starved result finally commits (or is withdrawn).
      if (mc_hs || !bus.mc_valid) begin
        stall_q <= 1'b0;
      end else if (starve_cnt == LIMIT) begin
        stall_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected RF write-port values are queued as
// stimulus is applied and compared one cycle later.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [3:0]  last_a = 4'd0;
  logic [31:0] last_d = 32'd0;

  wb_arbiter_if bus();

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.pipe_write_in = 1'b0;
    bus.pipe_rd_in    = 4'd0;
    bus.pipe_data_in  = 32'd0;
    bus.mc_issue      = 1'b0;
    bus.mc_issue_rd   = 4'd0;
    bus.mc_valid      = 1'b0;
    bus.mc_rd         = 4'd0;
    bus.mc_data       = 32'd0;
  endtask

  // Queue the write-port value expected after the next edge; idle/dropped holds addr/data.
  task automatic push_wr(input logic we, input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    if (we) begin
      last_a = a;
      last_d = d;
    end
    w.we = we;
    w.a  = last_a;
    w.d  = last_d;
    exp_q.push_back(w);
  endtask

  task automatic issue(input logic [3:0] rd);
    bus.mc_issue    = 1'b1;
    bus.mc_issue_rd = rd;
  endtask

  task automatic pipe(input logic [3:0] rd, input logic [31:0] d);
    bus.pipe_write_in = 1'b1;
    bus.pipe_rd_in    = rd;
    bus.pipe_data_in  = d;
  endtask

  task automatic mc(input logic [3:0] rd, input logic [31:0] d);
    bus.mc_valid = 1'b1;
    bus.mc_rd    = rd;
    bus.mc_data  = d;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask, bus.stall_req} !== 54'd0) begin
      bad++;
      $display("FAIL reset_state got we=%b a=%h d=%h busy=%h stall=%b want all zero",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask, bus.stall_req);
    end
    total++;
    if (bus.mc_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mc_ready got=%b want=1", bus.mc_ready);
    end
  endtask

  task automatic test_pipe_write();
    pipe(4'd3, 32'hDEADBEEF);
    push_wr(1'b1, 4'd3, 32'hDEADBEEF);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL pipe_wr got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL pipe_idle got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
  endtask

  task automatic test_issue_commit();
    issue(4'd5);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL issue_hold got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    total++;
    if (bus.busy_mask !== 16'h0020) begin
      bad++;
      $display("FAIL issue_busy got=%h want=0020", bus.busy_mask);
    end
    bus.mc_issue_rd = 4'd5;
    #1;
    total++;
    if (bus.issue_ok !== 1'b0) begin
      bad++;
      $display("FAIL issue_ok_busy got=%b want=0", bus.issue_ok);
    end
    bus.mc_issue_rd = 4'd4;
    #1;
    total++;
    if (bus.issue_ok !== 1'b1) begin
      bad++;
      $display("FAIL issue_ok_free got=%b want=1", bus.issue_ok);
    end
    mc(4'd5, 32'h12);
    #1;
    total++;
    if (bus.mc_ready !== 1'b1) begin
      bad++;
      $display("FAIL commit_ready got=%b want=1", bus.mc_ready);
    end
    push_wr(1'b1, 4'd5, 32'h12);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL commit_wr got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    total++;
    if (bus.busy_mask !== 16'h0000) begin
      bad++;
      $display("FAIL commit_busy got=%h want=0000", bus.busy_mask);
    end
  endtask

  task automatic test_waw();
    issue(4'd7);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL waw_issue got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    pipe(4'd7, 32'hAA);
    push_wr(1'b1, 4'd7, 32'hAA);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL waw_pipe got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    mc(4'd7, 32'hBB);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL waw_drop got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    total++;
    if (bus.busy_mask !== 16'h0000) begin
      bad++;
      $display("FAIL waw_busy got=%h want=0000", bus.busy_mask);
    end
    // A fresh issue/commit to rd 7 must write, proving stale[7] cleared.
    issue(4'd7);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    mc(4'd7, 32'hCC);
    push_wr(1'b1, 4'd7, 32'hCC);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL waw_stale_clr got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
  endtask

  task automatic test_starve();
    for (int k = 0; k < 6; k++) begin
      pipe(4'd1, 32'h100 + 32'(k));
      mc(4'd9, 32'h99);
      #1;
      total++;
      if (bus.mc_ready !== 1'b0) begin
        bad++;
        $display("FAIL starve_ready k=%0d got=%b want=0", k, bus.mc_ready);
      end
      push_wr(1'b1, 4'd1, 32'h100 + 32'(k));
      tick();
      e = exp_q.pop_front();
      total++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
        bad++;
        $display("FAIL starve_wr k=%0d got=%h want=%h", k, {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
      end
      total++;
      if (bus.stall_req !== (k >= 4)) begin
        bad++;
        $display("FAIL starve_stall k=%0d got=%b want=%b", k, bus.stall_req, (k >= 4));
      end
    end
    bus.pipe_write_in = 1'b0;
    #1;
    total++;
    if (bus.mc_ready !== 1'b1) begin
      bad++;
      $display("FAIL starve_release got=%b want=1", bus.mc_ready);
    end
    push_wr(1'b1, 4'd9, 32'h99);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL starve_commit got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    total++;
    if (bus.stall_req !== 1'b0) begin
      bad++;
      $display("FAIL starve_stall_fall got=%b want=0", bus.stall_req);
    end
  endtask

  task automatic test_same_cycle();
    issue(4'd2);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    issue(4'd2);
    mc(4'd2, 32'h22);
    push_wr(1'b1, 4'd2, 32'h22);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL iss_cmt_wr got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    total++;
    if (bus.busy_mask !== 16'h0004) begin
      bad++;
      $display("FAIL iss_cmt_busy got=%h want=0004", bus.busy_mask);
    end
    mc(4'd2, 32'h23);
    push_wr(1'b1, 4'd2, 32'h23);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask} !== {e, 16'h0000}) begin
      bad++;
      $display("FAIL iss_cmt_second got=%h busy=%h want=%h busy=0000",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, e);
    end
  endtask

  task automatic test_pipe_vs_commit();
    issue(4'd4);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    pipe(4'd4, 32'h44);
    mc(4'd4, 32'h45);
    #1;
    total++;
    if (bus.mc_ready !== 1'b0) begin
      bad++;
      $display("FAIL pipe_cmt_ready got=%b want=0", bus.mc_ready);
    end
    push_wr(1'b1, 4'd4, 32'h44);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== e) begin
      bad++;
      $display("FAIL pipe_cmt_wr got=%h want=%h", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, e);
    end
    mc(4'd4, 32'h45);
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask} !== {e, 16'h0000}) begin
      bad++;
      $display("FAIL pipe_cmt_drop got=%h busy=%h want=%h busy=0000",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, e);
    end
  endtask

  task automatic test_issue_vs_pipe();
    issue(4'd6);
    pipe(4'd6, 32'h66);
    push_wr(1'b1, 4'd6, 32'h66);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask} !== {e, 16'h0040}) begin
      bad++;
      $display("FAIL iss_pipe_wr got=%h busy=%h want=%h busy=0040",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, e);
    end
    mc(4'd6, 32'h67);
    push_wr(1'b1, 4'd6, 32'h67);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask} !== {e, 16'h0000}) begin
      bad++;
      $display("FAIL iss_pipe_commit got=%h busy=%h want=%h busy=0000",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, e);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 4; r < 8; r++) begin
      issue(4'(r));
      push_wr(1'b0, 4'd0, 32'd0);
      tick();
      clear_in();
      e = exp_q.pop_front();
    end
    // Blocked writes target busy rd 7, leaving stale[7] set before reset.
    for (int k = 0; k < 5; k++) begin
      pipe(4'd7, 32'h200 + 32'(k));
      mc(4'd8, 32'h88);
      push_wr(1'b1, 4'd7, 32'h200 + 32'(k));
      tick();
      e = exp_q.pop_front();
    end
    total++;
    if ({bus.busy_mask, bus.stall_req} !== {16'h00F0, 1'b1}) begin
      bad++;
      $display("FAIL mid_setup busy=%h stall=%b want busy=00f0 stall=1", bus.busy_mask, bus.stall_req);
    end
    reset = 1'b1;
    issue(4'd3);
    last_a = 4'd0;
    last_d = 32'd0;
    push_wr(1'b0, 4'd0, 32'd0);
    tick();
    reset = 1'b0;
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask, bus.stall_req} !== {e, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got=%h busy=%h stall=%b want=%h busy=0000 stall=0",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, bus.stall_req, e);
    end
    mc(4'd7, 32'h77);
    push_wr(1'b1, 4'd7, 32'h77);
    tick();
    clear_in();
    e = exp_q.pop_front();
    total++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_mask} !== {e, 16'h0000}) begin
      bad++;
      $display("FAIL mid_post_commit got=%h busy=%h want=%h busy=0000",
               {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, bus.busy_mask, e);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_pipe_write();
    test_issue_commit();
    test_waw();
    test_starve();
    test_same_cycle();
    test_pipe_vs_commit();
    test_issue_vs_pipe();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
